// File: rtl/datapath_pkg.sv
// Shared datapath types for the tensor-core load/store path.
// Holds the word type and the dcache port arbiter state encoding.
package datapath_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_S = 2'd1,
        OWN_M = 2'd2
    } arb_state_t;

    localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/dcache_port_arb.sv
// Shares the single dcache port between the scalar and matrix LS units.
// Define DCACHE_ARB_RR_EN for round-robin; default is fixed scalar priority.
module dcache_port_arb
    import datapath_pkg::*;
(
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  s_dmemREN,
    input  logic                  s_dmemWEN,
    input  word_t                 s_dmemaddr,
    input  word_t                 s_dmemstore,
    output word_t                 s_dmem_in,
    output logic                  s_dhit,
    input  logic                  m_dmemREN,
    input  logic                  m_dmemWEN,
    input  word_t                 m_dmemaddr,
    input  word_t                 m_dmemstore,
    output word_t                 m_dmem_in,
    output logic                  m_dhit,
    output logic                  dmemREN,
    output logic                  dmemWEN,
    output word_t                 dmemaddr,
    output word_t                 dmemstore,
    input  word_t                 dmem_in,
    input  logic                  dhit_in,
    output logic [1:0]            grant,
    output logic [WAIT_CNT_W-1:0] wait_cnt
);

    arb_state_t state, state_n, pick;
    logic s_req, m_req, m_first;
    logic [WAIT_CNT_W-1:0] wait_q;

    assign s_req = s_dmemREN | s_dmemWEN;
    assign m_req = m_dmemREN | m_dmemWEN;

`ifdef DCACHE_ARB_RR_EN
    logic last_m;

    // Contention goes to whoever did not own the port last.
    assign m_first = ~last_m;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_m <= 1'b1;
        end else if (state_n != IDLE) begin
            last_m <= (state_n == OWN_M);
        end
    end
`else
    assign m_first = 1'b0;
`endif

    always_comb begin
        pick = IDLE;
        if (s_req && m_req) begin
            pick = m_first ? OWN_M : OWN_S;
        end else if (s_req) begin
            pick = OWN_S;
        end else if (m_req) begin
            pick = OWN_M;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                state_n = pick;
            end
            OWN_S: begin
                if (dhit_in) begin
                    state_n = pick;
                end else if (!s_req) begin
                    state_n = IDLE;
                end
            end
            OWN_M: begin
                if (dhit_in) begin
                    state_n = pick;
                end else if (!m_req) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        dmemaddr  = '0;
        dmemstore = '0;
        s_dhit    = 1'b0;
        m_dhit    = 1'b0;
        s_dmem_in = '0;
        m_dmem_in = '0;
        unique case (state)
            OWN_S: begin
                // A write wins over a simultaneous read.
                dmemWEN   = s_dmemWEN;
                dmemREN   = s_dmemREN & ~s_dmemWEN;
                dmemaddr  = s_dmemaddr;
                dmemstore = s_dmemstore;
                s_dhit    = dhit_in;
                s_dmem_in = dmem_in;
            end
            OWN_M: begin
                dmemWEN   = m_dmemWEN;
                dmemREN   = m_dmemREN & ~m_dmemWEN;
                dmemaddr  = m_dmemaddr;
                dmemstore = m_dmemstore;
                m_dhit    = dhit_in;
                m_dmem_in = dmem_in;
            end
            default: begin
            end
        endcase
    end

    assign grant = {state == OWN_M, state == OWN_S};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_q <= '0;
        end else if (((state == OWN_S) && m_req) ||
                     ((state == OWN_M) && s_req)) begin
            if (wait_q != '1) begin
                wait_q <= wait_q + 1'b1;
            end
        end
    end

    assign wait_cnt = wait_q;

endmodule

// File: tb/tb_dcache_port_arb.sv
// Directed self-checking bench for dcache_port_arb.
// Expectations follow DCACHE_ARB_RR_EN when it is defined.
module tb_dcache_port_arb;
    import datapath_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        s_dmemREN, s_dmemWEN, m_dmemREN, m_dmemWEN;
    word_t       s_dmemaddr, s_dmemstore, m_dmemaddr, m_dmemstore;
    word_t       s_dmem_in, m_dmem_in, dmemaddr, dmemstore, dmem_in;
    logic        s_dhit, m_dhit, dmemREN, dmemWEN, dhit_in;
    logic [1:0]  grant;
    logic [15:0] wait_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    dcache_port_arb dut (
        .CLK(CLK), .nRST(nRST),
        .s_dmemREN(s_dmemREN), .s_dmemWEN(s_dmemWEN),
        .s_dmemaddr(s_dmemaddr), .s_dmemstore(s_dmemstore),
        .s_dmem_in(s_dmem_in), .s_dhit(s_dhit),
        .m_dmemREN(m_dmemREN), .m_dmemWEN(m_dmemWEN),
        .m_dmemaddr(m_dmemaddr), .m_dmemstore(m_dmemstore),
        .m_dmem_in(m_dmem_in), .m_dhit(m_dhit),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dmem_in(dmem_in), .dhit_in(dhit_in),
        .grant(grant), .wait_cnt(wait_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, checks 1 unit later.
    task automatic ck();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        s_dmemREN = 0; s_dmemWEN = 0; s_dmemaddr = 0; s_dmemstore = 0;
        m_dmemREN = 0; m_dmemWEN = 0; m_dmemaddr = 0; m_dmemstore = 0;
        dmem_in = 0; dhit_in = 0;
        ck(); ck(); #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_wait", 32'(wait_cnt), 32'h0);
        chk("rst_ren", 32'(dmemREN), 32'h0);
        chk("rst_wen", 32'(dmemWEN), 32'h0);
        chk("rst_sdhit", 32'(s_dhit), 32'h0);
        ck(); nRST = 1'b1;

        // Simultaneous writes, hit latency 2
        ck();
        s_dmemWEN = 1; s_dmemaddr = 32'h200; s_dmemstore = 32'h11;
        m_dmemWEN = 1; m_dmemaddr = 32'h300; m_dmemstore = 32'h22;
        #1 chk("d0_grant", 32'(grant), 32'h0);
        ck(); #1;
        chk("d1_grant", 32'(grant), 32'h1);
        chk("d1_wen", 32'(dmemWEN), 32'h1);
        chk("d1_addr", dmemaddr, 32'h200);
        chk("d1_store", dmemstore, 32'h11);
        ck(); #1;
        chk("d2_wait", 32'(wait_cnt), 32'd1);
        ck(); dhit_in = 1;
        #1;
        chk("d3_shit", 32'(s_dhit), 32'h1);
        chk("d3_mhit", 32'(m_dhit), 32'h0);
        chk("d3_wait", 32'(wait_cnt), 32'd2);
        ck(); dhit_in = 0;
        #1;
`ifdef DCACHE_ARB_RR_EN
        chk("d4_grant", 32'(grant), 32'h2);
        chk("d4_addr", dmemaddr, 32'h300);
        chk("d4_store", dmemstore, 32'h22);
`else
        chk("d4_grant", 32'(grant), 32'h1);
        chk("d4_addr", dmemaddr, 32'h200);
`endif
        chk("d4_wait", 32'(wait_cnt), 32'd3);
        ck(); #1;
        chk("d5_wait", 32'(wait_cnt), 32'd4);
        ck(); dhit_in = 1;
`ifdef DCACHE_ARB_RR_EN
        m_dmemWEN = 0;
`endif
        #1;
`ifdef DCACHE_ARB_RR_EN
        chk("d6_mhit", 32'(m_dhit), 32'h1);
        chk("d6_shit", 32'(s_dhit), 32'h0);
`else
        chk("d6_shit", 32'(s_dhit), 32'h1);
        chk("d6_mhit", 32'(m_dhit), 32'h0);
`endif
        chk("d6_wait", 32'(wait_cnt), 32'd5);
        ck(); dhit_in = 0; m_dmemWEN = 1;
        #1;
        chk("d7_grant", 32'(grant), 32'h1);
        chk("d7_wait", 32'(wait_cnt), 32'd6);
        ck(); dhit_in = 1; s_dmemWEN = 0;
        #1;
        chk("d8_shit", 32'(s_dhit), 32'h1);
        chk("d8_wait", 32'(wait_cnt), 32'd7);

        // Matrix owner aborts before any hit
        ck(); dhit_in = 0;
        #1;
        chk("d9_grant", 32'(grant), 32'h2);
        chk("d9_wen", 32'(dmemWEN), 32'h1);
        chk("d9_wait", 32'(wait_cnt), 32'd8);
        m_dmemWEN = 0;
        #1;
        chk("abort_wen", 32'(dmemWEN), 32'h0);
        chk("abort_mhit", 32'(m_dhit), 32'h0);
        ck(); #1;
        chk("abort_idle", 32'(grant), 32'h0);
        chk("abort_wait", 32'(wait_cnt), 32'd8);

        // Scalar read alone, hit 3 cycles after grant
        ck();
        s_dmemREN = 1; s_dmemaddr = 32'h100;
        #1;
        chk("r0_grant", 32'(grant), 32'h0);
        chk("r0_ren", 32'(dmemREN), 32'h0);
        ck(); #1;
        chk("r1_grant", 32'(grant), 32'h1);
        chk("r1_ren", 32'(dmemREN), 32'h1);
        chk("r1_addr", dmemaddr, 32'h100);
        chk("r1_mhit", 32'(m_dhit), 32'h0);
        ck(); #1;
        chk("r2_shit", 32'(s_dhit), 32'h0);
        ck(); #1;
        chk("r3_mhit", 32'(m_dhit), 32'h0);
        ck();
        dhit_in = 1; dmem_in = 32'hDEADBEEF; s_dmemREN = 0;
        #1;
        chk("r4_shit", 32'(s_dhit), 32'h1);
        chk("r4_sdata", s_dmem_in, 32'hDEADBEEF);
        chk("r4_mhit", 32'(m_dhit), 32'h0);
        chk("r4_mdata", m_dmem_in, 32'h0);
        ck(); dhit_in = 0; dmem_in = 0;
        #1;
        chk("r5_idle", 32'(grant), 32'h0);
        chk("r5_wait", 32'(wait_cnt), 32'd8);

        // Hit while idle is ignored
        dhit_in = 1; dmem_in = 32'h55;
        #1;
        chk("idle_shit", 32'(s_dhit), 32'h0);
        chk("idle_sdata", s_dmem_in, 32'h0);
        ck(); dhit_in = 0; dmem_in = 0;
        #1 chk("idle_stay", 32'(grant), 32'h0);

        // REN and WEN together: write wins
        ck();
        s_dmemREN = 1; s_dmemWEN = 1; s_dmemaddr = 32'h40;
        ck(); #1;
        chk("rw_wen", 32'(dmemWEN), 32'h1);
        chk("rw_ren", 32'(dmemREN), 32'h0);
        chk("rw_addr", dmemaddr, 32'h40);
        ck(); dhit_in = 1; s_dmemREN = 0; s_dmemWEN = 0;
        #1 chk("rw_shit", 32'(s_dhit), 32'h1);
        ck(); dhit_in = 0;
        #1 chk("rw_idle", 32'(grant), 32'h0);

        // Reset pulse during OWN_M
        ck();
        m_dmemREN = 1; m_dmemaddr = 32'h500;
        ck(); #1;
        chk("f1_grant", 32'(grant), 32'h2);
        chk("f1_ren", 32'(dmemREN), 32'h1);
        dmem_in = 32'h1234;
        nRST = 0;
        #1;
        chk("f1r_grant", 32'(grant), 32'h0);
        chk("f1r_ren", 32'(dmemREN), 32'h0);
        chk("f1r_addr", dmemaddr, 32'h0);
        chk("f1r_mdata", m_dmem_in, 32'h0);
        chk("f1r_wait", 32'(wait_cnt), 32'h0);
        m_dmemREN = 0; dmem_in = 0;
        ck();
        nRST = 1; s_dmemREN = 1; s_dmemaddr = 32'h600;
        #1 chk("f2_grant", 32'(grant), 32'h0);
        ck(); #1;
        chk("f3_grant", 32'(grant), 32'h1);
        chk("f3_addr", dmemaddr, 32'h600);
        ck(); dhit_in = 1; s_dmemREN = 0;
        ck(); dhit_in = 0;
        #1 chk("f5_idle", 32'(grant), 32'h0);

        // Long contention saturates the wait counter
        ck();
        s_dmemREN = 1; m_dmemREN = 1;
        for (int i = 1; i <= 65535; i++) begin
            ck();
        end
        #1;
        chk("sat_pre", 32'(wait_cnt), 32'hFFFE);
        ck(); #1;
        chk("sat_hit", 32'(wait_cnt), 32'hFFFF);
        for (int i = 0; i < 4; i++) begin
            ck();
        end
        #1;
        chk("sat_hold", 32'(wait_cnt), 32'hFFFF);
        chk("sat_owner", 32'(grant == 2'b00), 32'h0);
        s_dmemREN = 0; m_dmemREN = 0;
        ck();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
